// File: rtl/eager_fork_n.sv
// ---------------------------------------------------------------------------
// eager_fork_n
//   Eager dataflow fork. Each token on the input side is offered to SIZE
//   output channels at once. A channel may accept the token in any cycle,
//   independently of the others. The upstream token is consumed only after
//   every channel has taken it, or is taking it in the current cycle. Data is
//   never registered. The only state is one "pending" bit per channel, and it
//   marks the channels that still owe a transfer for the current token.
//
// Ports
//   clk        : clock, rising-edge active
//   rst        : synchronous active-low reset
//   ins        : incoming token data            [DATA_TYPE-1:0]
//   ins_valid  : upstream token present
//   ins_ready  : upstream token consumed this cycle
//   outs       : replicated data, channel i at [i*DATA_TYPE +: DATA_TYPE]
//   outs_valid : per-channel valid              [SIZE-1:0]
//   outs_ready : per-channel downstream ready   [SIZE-1:0]
//
// Also contains and_n, the N-input AND reduction cell used for ins_ready.
// ---------------------------------------------------------------------------

// and_n: N-input AND reduction.
//   ins  : operands [SIZE-1:0]
//   outs : AND of all operands
module and_n #(
    parameter int SIZE = 2
) (
    input  logic [SIZE-1:0] ins,
    output logic            outs
);
    assign outs = &ins;
endmodule

module eager_fork_n #(
    parameter int SIZE      = 2,
    parameter int DATA_TYPE = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_TYPE-1:0]      ins,
    input  logic                      ins_valid,
    output logic                      ins_ready,
    output logic [SIZE*DATA_TYPE-1:0] outs,
    output logic [SIZE-1:0]           outs_valid,
    input  logic [SIZE-1:0]           outs_ready
);

    logic [SIZE-1:0] pending_q;
    logic [SIZE-1:0] pending_d;
    logic [SIZE-1:0] transfer;
    logic [SIZE-1:0] done;

    // Every channel sees the same data.
    assign outs = {SIZE{ins}};

    // A channel is "done" if it already took the token or takes it now.
    // done depends only on pending and outs_ready. This keeps ins_ready
    // free of any combinational path from ins_valid.
    always_comb begin
        outs_valid = {SIZE{ins_valid}} & pending_q;
        transfer   = outs_valid & outs_ready;
        done       = ~pending_q | outs_ready;
    end

    and_n #(
        .SIZE (SIZE)
    ) u_and_n (
        .ins  (done),
        .outs (ins_ready)
    );

    // When the token is consumed, every channel is re-armed for the next
    // token. Otherwise, only the channels that transferred this cycle are
    // cleared. Without ins_valid there are no transfers, so pending holds.
    always_comb begin
        pending_d = pending_q & ~transfer;
        if (ins_valid && ins_ready) begin
            pending_d = {SIZE{1'b1}};
        end
    end

    // Reset re-arms all channels. Any partial delivery is discarded, and the
    // held token is offered to every channel again.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= {SIZE{1'b1}};
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_eager_fork_n.sv
// ---------------------------------------------------------------------------
// tb_eager_fork_n
//   Directed and random checks for eager_fork_n (SIZE=3, DATA_TYPE=8).
//   A second instance with SIZE=1 covers the degenerate wire case.
// ---------------------------------------------------------------------------
module tb_eager_fork_n;

    localparam int SIZE      = 3;
    localparam int DATA_TYPE = 8;

    logic                      clk;
    logic                      rst;
    logic [DATA_TYPE-1:0]      ins;
    logic                      ins_valid;
    logic                      ins_ready;
    logic [SIZE*DATA_TYPE-1:0] outs;
    logic [SIZE-1:0]           outs_valid;
    logic [SIZE-1:0]           outs_ready;

    logic [DATA_TYPE-1:0]      ins1;
    logic                      ins_valid1;
    logic                      ins_ready1;
    logic [DATA_TYPE-1:0]      outs1;
    logic [0:0]                outs_valid1;
    logic [0:0]                outs_ready1;

    int n_checks;
    int n_fail;

    // Reference state for the random scoreboard.
    logic [SIZE-1:0]      pend_m;
    logic [DATA_TYPE-1:0] cur_tok;
    logic [DATA_TYPE-1:0] exp_q[$];
    int                   del_cnt[SIZE];

    eager_fork_n #(
        .SIZE      (SIZE),
        .DATA_TYPE (DATA_TYPE)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    eager_fork_n #(
        .SIZE      (1),
        .DATA_TYPE (DATA_TYPE)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins1),
        .ins_valid  (ins_valid1),
        .ins_ready  (ins_ready1),
        .outs       (outs1),
        .outs_valid (outs_valid1),
        .outs_ready (outs_ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge. Inputs change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ins = 8'h11;
        ins_valid = 1'b1;
        outs_ready = 3'b010;
        step();
        step();
        rst = 1'b1;
        outs_ready = 3'b000;
        @(negedge clk);
        n_checks++;
        if (outs_valid !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL reset_ov: got %b want %b", outs_valid, 3'b111);
        end
        n_checks++;
        if (ins_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ir: got %b want %b", ins_ready, 1'b0);
        end
        ins_valid = 1'b0;
        #1;
        n_checks++;
        if (outs_valid !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_ov_idle: got %b want %b", outs_valid, 3'b000);
        end
        step();
    endtask

    task automatic test_full_pass();
        ins = 8'hA5;
        ins_valid = 1'b1;
        outs_ready = 3'b111;
        @(negedge clk);
        n_checks++;
        if (outs_valid !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL pass_ov: got %b want %b", outs_valid, 3'b111);
        end
        n_checks++;
        if (outs !== 24'hA5A5A5) begin
            n_fail++;
            $display("[TB] FAIL pass_data: got %h want %h", outs, 24'hA5A5A5);
        end
        n_checks++;
        if (ins_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pass_ir: got %b want %b", ins_ready, 1'b1);
        end
        step();
        // Token consumed, so every channel must be re-armed.
        ins_valid = 1'b1;
        outs_ready = 3'b000;
        @(negedge clk);
        n_checks++;
        if (outs_valid !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL pass_rearm: got %b want %b", outs_valid, 3'b111);
        end
        // ins_ready must not depend on ins_valid.
        ins_valid = 1'b0;
        outs_ready = 3'b111;
        #1;
        n_checks++;
        if (ins_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ir_no_valid_path: got %b want %b", ins_ready, 1'b1);
        end
        step();
    endtask

    task automatic test_partial();
        logic [SIZE-1:0] rdy_seq[3];
        logic [SIZE-1:0] ov_seq[3];
        logic            ir_seq[3];
        int              ch0_xfers;
        rdy_seq = '{3'b001, 3'b000, 3'b110};
        ov_seq  = '{3'b111, 3'b110, 3'b110};
        ir_seq  = '{1'b0, 1'b0, 1'b1};
        ch0_xfers = 0;
        ins = 8'h3C;
        ins_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            outs_ready = rdy_seq[k];
            @(negedge clk);
            n_checks++;
            if (outs_valid !== ov_seq[k]) begin
                n_fail++;
                $display("[TB] FAIL partial_ov[%0d]: got %b want %b", k, outs_valid, ov_seq[k]);
            end
            n_checks++;
            if (ins_ready !== ir_seq[k]) begin
                n_fail++;
                $display("[TB] FAIL partial_ir[%0d]: got %b want %b", k, ins_ready, ir_seq[k]);
            end
            if (outs_valid[0] && outs_ready[0]) ch0_xfers++;
            step();
        end
        n_checks++;
        if (ch0_xfers != 1) begin
            n_fail++;
            $display("[TB] FAIL partial_ch0_once: got %0d want %0d", ch0_xfers, 1);
        end
    endtask

    task automatic test_valid_drop();
        ins = 8'h5A;
        ins_valid = 1'b1;
        outs_ready = 3'b010;
        @(negedge clk);
        n_checks++;
        if (outs_valid !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL drop_first_ov: got %b want %b", outs_valid, 3'b111);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            ins_valid = 1'b0;
            outs_ready = 3'b000;
            @(negedge clk);
            n_checks++;
            if (outs_valid !== 3'b000 || ins_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL drop_idle[%0d]: got ov=%b ir=%b want ov=000 ir=0", k, outs_valid, ins_ready);
            end
            step();
        end
        ins_valid = 1'b1;
        outs_ready = 3'b111;
        @(negedge clk);
        n_checks++;
        if (outs_valid !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL drop_resume_ov: got %b want %b", outs_valid, 3'b101);
        end
        n_checks++;
        if (ins_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drop_resume_ir: got %b want %b", ins_ready, 1'b1);
        end
        step();
    endtask

    task automatic test_reset_mid();
        ins = 8'h77;
        ins_valid = 1'b1;
        outs_ready = 3'b100;
        step();
        outs_ready = 3'b000;
        @(negedge clk);
        n_checks++;
        if (outs_valid !== 3'b011) begin
            n_fail++;
            $display("[TB] FAIL midrst_before: got %b want %b", outs_valid, 3'b011);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs_valid !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL midrst_after: got %b want %b", outs_valid, 3'b111);
        end
        n_checks++;
        if (ins_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_ir: got %b want %b", ins_ready, 1'b0);
        end
        step();
    endtask

    task automatic test_simultaneous();
        ins = 8'hAB;
        ins_valid = 1'b1;
        outs_ready = 3'b001;
        step();
        // The two channels that are still pending both finish in this cycle.
        outs_ready = 3'b110;
        @(negedge clk);
        n_checks++;
        if (ins_ready !== 1'b1 || outs_valid !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL simult_last: got ov=%b ir=%b want ov=110 ir=1", outs_valid, ins_ready);
        end
        step();
        outs_ready = 3'b000;
        @(negedge clk);
        n_checks++;
        if (outs_valid !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL simult_rearm: got %b want %b", outs_valid, 3'b111);
        end
        step();
    endtask

    task automatic test_size1();
        for (int k = 0; k < 8; k++) begin
            ins1 = DATA_TYPE'($urandom);
            ins_valid1 = k[0];
            outs_ready1 = k[1];
            @(negedge clk);
            n_checks++;
            if (outs1 !== ins1 || outs_valid1 !== ins_valid1 || ins_ready1 !== outs_ready1[0]) begin
                n_fail++;
                $display("[TB] FAIL size1_wire[%0d]: got outs=%h ov=%b ir=%b want outs=%h ov=%b ir=%b",
                         k, outs1, outs_valid1, ins_ready1, ins1, ins_valid1, outs_ready1);
            end
            step();
        end
    endtask

    // One random cycle. The reference pending model predicts the handshake,
    // and the token queue checks the data and the delivery order per channel.
    task automatic random_cycle(input logic v, input logic [SIZE-1:0] r);
        logic [SIZE-1:0]      exp_ov;
        logic                 exp_ir;
        logic [DATA_TYPE-1:0] got;
        ins = cur_tok;
        ins_valid = v;
        outs_ready = r;
        @(negedge clk);
        exp_ov = {SIZE{v}} & pend_m;
        exp_ir = &(~pend_m | r);
        n_checks++;
        if (outs_valid !== exp_ov) begin
            n_fail++;
            $display("[TB] FAIL rnd_ov: got %b want %b", outs_valid, exp_ov);
        end
        n_checks++;
        if (ins_ready !== exp_ir) begin
            n_fail++;
            $display("[TB] FAIL rnd_ir: got %b want %b", ins_ready, exp_ir);
        end
        n_checks++;
        if (ins_ready === 1'b1 && (pend_m & ~r) != '0) begin
            n_fail++;
            $display("[TB] FAIL rnd_ir_blocked: got ir=%b with pend=%b rdy=%b want 0", ins_ready, pend_m, r);
        end
        for (int i = 0; i < SIZE; i++) begin
            if (outs_valid[i] === 1'b1 && outs_ready[i] === 1'b1) begin
                n_checks++;
                if (del_cnt[i] >= exp_q.size()) begin
                    n_fail++;
                    $display("[TB] FAIL sb_extra ch%0d: got delivery %0d want at most %0d", i, del_cnt[i] + 1, exp_q.size());
                end else begin
                    got = outs[i*DATA_TYPE +: DATA_TYPE];
                    if (got !== exp_q[del_cnt[i]]) begin
                        n_fail++;
                        $display("[TB] FAIL sb_data ch%0d: got %h want %h", i, got, exp_q[del_cnt[i]]);
                    end
                    del_cnt[i]++;
                end
            end
        end
        while (exp_q.size() > 0 && del_cnt[0] > 0 && del_cnt[1] > 0 && del_cnt[2] > 0) begin
            void'(exp_q.pop_front());
            for (int i = 0; i < SIZE; i++) del_cnt[i]--;
        end
        @(posedge clk);
        if (v && exp_ir) begin
            pend_m = '1;
            cur_tok = DATA_TYPE'($urandom);
            exp_q.push_back(cur_tok);
        end else begin
            pend_m = pend_m & ~(exp_ov & r);
        end
        #1;
    endtask

    task automatic test_random();
        rst = 1'b0;
        ins_valid = 1'b0;
        outs_ready = '0;
        step();
        rst = 1'b1;
        pend_m = '1;
        exp_q.delete();
        for (int i = 0; i < SIZE; i++) del_cnt[i] = 0;
        cur_tok = DATA_TYPE'($urandom);
        exp_q.push_back(cur_tok);
        for (int c = 0; c < 10000; c++) begin
            random_cycle($urandom_range(3, 0) != 0, SIZE'($urandom_range(7, 0)));
        end
        // Drain the token in flight. Only the freshly generated token may remain.
        random_cycle(1'b1, 3'b111);
        n_checks++;
        if (exp_q.size() != 1 || del_cnt[0] != 0 || del_cnt[1] != 0 || del_cnt[2] != 0) begin
            n_fail++;
            $display("[TB] FAIL sb_drain: got q=%0d cnt=%0d/%0d/%0d want q=1 cnt=0/0/0",
                     exp_q.size(), del_cnt[0], del_cnt[1], del_cnt[2]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0;
        ins = '0;
        ins_valid = 1'b0;
        outs_ready = '0;
        ins1 = '0;
        ins_valid1 = 1'b0;
        outs_ready1 = '0;
        step();
        test_reset();
        test_full_pass();
        test_partial();
        test_valid_drop();
        test_reset_mid();
        test_simultaneous();
        test_size1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
